// File: rtl/compress_pkg.sv
// compress_pkg: shared match-type encoding and dictionary geometry for the compressor
// stages (dictionary buffer, comparator array, encoder).
package compress_pkg;
    typedef enum logic [1:0] {
        NONE   = 2'b00,
        PART16 = 2'b01,
        PART24 = 2'b10,
        FULL   = 2'b11
    } match_type_t;

    localparam int DICT_WORD_DEFAULT  = 32;
    localparam int DICT_ENTRY_DEFAULT = 16;
endpackage

// File: rtl/dict_shift_reg.sv
// dict_shift_reg: FIFO-replacement dictionary storage; insert pushes at entry 0 and
// drops the oldest entry, with a thermometer occupancy mask.
module dict_shift_reg
    import compress_pkg::*;
#(
    parameter int DICT_WORD  = DICT_WORD_DEFAULT,
    parameter int DICT_ENTRY = DICT_ENTRY_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           insert,
    input  logic [DICT_WORD-1:0]           din,
    output logic [DICT_WORD*DICT_ENTRY-1:0] dict,
    output logic [DICT_ENTRY-1:0]          valid
);
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            dict  <= '0;
            valid <= '0;
        end else if (insert) begin
            dict  <= {dict[DICT_WORD*(DICT_ENTRY-1)-1:0], din};
            valid <= {valid[DICT_ENTRY-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/dict_buffer.sv
// dict_buffer: holds the incoming word for the comparator array and inserts it into the
// dictionary when committed downstream, unless it fully matched or is zero.
module dict_buffer
    import compress_pkg::*;
#(
    parameter int DICT_WORD  = DICT_WORD_DEFAULT,
    parameter int DICT_ENTRY = DICT_ENTRY_DEFAULT,
    localparam int FILL_W    = $clog2(DICT_ENTRY) + 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_clear,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [DICT_WORD-1:0]            i_word,
    output logic [DICT_WORD-1:0]            o_word,
    output logic                            o_word_valid,
    input  logic [1:0]                      i_type_matched,
    input  logic                            i_out_ready,
    output logic [DICT_WORD*DICT_ENTRY-1:0] o_dict,
    output logic [DICT_ENTRY-1:0]           o_dict_valid,
    output logic [FILL_W-1:0]               o_fill
);
    logic commit, accept, insert;

    assign o_ready = !i_clear && (!o_word_valid || i_out_ready);
    assign commit  = o_word_valid && i_out_ready;
    assign accept  = i_valid && o_ready;
    // A clear in the same cycle as a commit suppresses the insertion.
    assign insert  = commit && !i_clear && match_type_t'(i_type_matched) != FULL && o_word != '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_word       <= '0;
            o_word_valid <= 1'b0;
        end else if (i_clear) begin
            o_word_valid <= 1'b0;
        end else if (accept) begin
            o_word       <= i_word;
            o_word_valid <= 1'b1;
        end else if (commit) begin
            o_word_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear)
            o_fill <= '0;
        else if (insert && o_fill != FILL_W'(DICT_ENTRY))
            o_fill <= o_fill + 1'b1;
    end

    dict_shift_reg #(
        .DICT_WORD (DICT_WORD),
        .DICT_ENTRY(DICT_ENTRY)
    ) u_shift (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .insert(insert),
        .din   (o_word),
        .dict  (o_dict),
        .valid (o_dict_valid)
    );
endmodule

// File: tb/tb_dict_buffer.sv
// tb_dict_buffer: directed vectors with a scoreboard of committed words checked by an
// independent monitor, plus direct checks of dictionary state at scenario boundaries.
module tb_dict_buffer;
    import compress_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, clear, valid, out_ready;
    logic [31:0]  word;
    logic [1:0]   type_m;
    logic         ready, word_valid;
    logic [31:0]  held;
    logic [511:0] dict;
    logic [15:0]  dict_valid;
    logic [4:0]   fill;

    int applied = 0;
    int errors  = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    dict_buffer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clear       (clear),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_word        (word),
        .o_word        (held),
        .o_word_valid  (word_valid),
        .i_type_matched(type_m),
        .i_out_ready   (out_ready),
        .o_dict        (dict),
        .o_dict_valid  (dict_valid),
        .o_fill        (fill)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] entry(input int k);
        return dict[k*32 +: 32];
    endfunction

    // Monitor: every word committed downstream must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (rst_n && !clear && word_valid && out_ready) begin
            if (expq.size() == 0) begin
                applied++;
                errors++;
                $display("FAIL mon_unexpected: got %0h expected none", held);
            end else begin
                chk("mon_word", held, expq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        valid = 1'b1;
        word  = w;
        expq.push_back(w);
        step();
    endtask

    task automatic idle();
        valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; out_ready = 1'b0;
        word = '0; type_m = NONE;
        step(); step();
        chk("rst_word", held, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_dict", dict, 0);
        chk("rst_dict_valid", dict_valid, 0);
        chk("rst_fill", fill, 0);

        // Basic stream: three inserts, one-cycle latency.
        rst_n = 1'b1; out_ready = 1'b1;
        send(32'hA1A1A1A1);
        chk("latency_word", held, 32'hA1A1A1A1);
        chk("latency_valid", word_valid, 1);
        send(32'hB2B2B2B2);
        send(32'hC3C3C3C3);
        idle();
        chk("s1_e0", entry(0), 32'hC3C3C3C3);
        chk("s1_e1", entry(1), 32'hB2B2B2B2);
        chk("s1_e2", entry(2), 32'hA1A1A1A1);
        chk("s1_fill", fill, 3);
        chk("s1_dvalid", dict_valid, 16'h0007);

        // Overfill with 17 words: oldest drops, fill saturates.
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_fill", fill, 0);
        for (int i = 0; i < 17; i++) send(32'h10000001 + i);
        idle();
        chk("full_fill", fill, 16);
        chk("full_dvalid", dict_valid, 16'hFFFF);
        chk("full_e15", entry(15), 32'h10000002);
        chk("full_e0", entry(0), 32'h10000011);

        // FULL match and zero word leave the dictionary alone.
        type_m = FULL;
        send(32'hDEADBEEF);
        idle();
        type_m = NONE;
        chk("fullm_fill", fill, 16);
        chk("fullm_e0", entry(0), 32'h10000011);
        send(32'h00000000);
        idle();
        chk("zero_fill", fill, 16);
        chk("zero_e0", entry(0), 32'h10000011);
        chk("zero_e15", entry(15), 32'h10000002);

        // Downstream stall: held word stays, upstream word waits.
        out_ready = 1'b0;
        send(32'h12345678);
        valid = 1'b1; word = 32'h9ABCDEF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", ready, 0);
            step();
            chk("stall_word", held, 32'h12345678);
            chk("stall_e0", entry(0), 32'h10000011);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", ready, 1);
        send(32'h9ABCDEF0);
        chk("release_e0", entry(0), 32'h12345678);
        chk("release_word", held, 32'h9ABCDEF0);
        chk("release_e15", entry(15), 32'h10000003);
        idle();
        chk("release2_e0", entry(0), 32'h9ABCDEF0);

        // Clear with fill 5 and a held word, colliding with a commit.
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h50000001 + i);
        idle();
        chk("pre_clr_fill", fill, 5);
        out_ready = 1'b0;
        send(32'h55555555);
        chk("pre_clr_held", word_valid, 1);
        clear = 1'b1; out_ready = 1'b1; valid = 1'b1; word = 32'h66666666;
        #1;
        chk("clr_ready", ready, 0);
        step();
        clear = 1'b0; valid = 1'b0;
        expq.delete();
        chk("clr2_fill", fill, 0);
        chk("clr2_dvalid", dict_valid, 0);
        chk("clr2_word_valid", word_valid, 0);
        chk("clr2_dict", dict, 0);
        step();
        chk("clr3_word_valid", word_valid, 0);

        // Reset mid-stream with valid asserted.
        send(32'h11111111);
        send(32'h22222222);
        rst_n = 1'b0; valid = 1'b1; word = 32'h33333333;
        step();
        chk("mrst_word", held, 0);
        chk("mrst_word_valid", word_valid, 0);
        chk("mrst_dict", dict, 0);
        chk("mrst_fill", fill, 0);
        step();
        chk("mrst_no_accept", word_valid, 0);
        chk("mrst_dvalid", dict_valid, 0);
        expq.delete();
        valid = 1'b0; rst_n = 1'b1;
        step();

        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule

// File: doc/dict_buffer.md
Name: dict_buffer

Overview:
- Stage-1 compressor dictionary and input holding stage. Sits directly upstream of the comparator array.
- Registers each incoming 32-bit word, presents it together with the flattened dictionary to the comparator array, and receives the match type back.
- When the current word is committed downstream, updates the dictionary with FIFO replacement: newest entry at index 0, oldest entry dropped.

Parameters:
- DICT_WORD, 32, width of a data word and of each dictionary entry.
- DICT_ENTRY, 16, number of dictionary entries; must be a power of 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_clear  in  1  synchronous dictionary flush, used at compression-block boundary.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block can accept a word this cycle.
- i_word  in  DICT_WORD  upstream data word.
- o_word  out  DICT_WORD  held word, driven to the comparator array input.
- o_word_valid  out  1  o_word holds an uncommitted word.
- i_type_matched  in  2  combinational match type from the comparator for o_word.
- i_out_ready  in  1  downstream encoder accepts the current word/type this cycle.
- o_dict  out  DICT_WORD*DICT_ENTRY  flattened dictionary; entry k at bits [k*DICT_WORD +: DICT_WORD].
- o_dict_valid  out  DICT_ENTRY  bit k set when entry k is occupied.
- o_fill  out  $clog2(DICT_ENTRY)+1  number of occupied entries.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_word=0, o_word_valid=0, all entries=0, o_dict_valid=0, o_fill=0.
  - Reset overrides i_clear and all handshakes.
- Handshake:
  - Define commit = o_word_valid & i_out_ready.
  - o_ready = !i_clear & (!o_word_valid | i_out_ready). This is combinational and gives one word per cycle of throughput.
  - Accept = i_valid & o_ready. On accept, o_word<=i_word and o_word_valid<=1 on the next edge.
  - Commit without accept: o_word_valid<=0; o_word keeps its value.
  - Latency: a word is on o_word exactly one cycle after it is accepted.
- Match type encoding (package): 2'b00 NONE, 2'b01 PART16 (upper 16 bits match), 2'b10 PART24 (upper 24 bits match), 2'b11 FULL.
- Dictionary update happens on the commit edge only, evaluated against the pre-edge dictionary:
  - Insert when i_type_matched != FULL and o_word != 0. Entry k <= entry k-1 for k=DICT_ENTRY-1..1, entry 0 <= o_word, and the last entry is discarded.
  - FULL match or all-zero word: no dictionary change.
- Occupancy:
  - On insert, o_fill increments and saturates at DICT_ENTRY.
  - o_dict_valid is {o_dict_valid[DICT_ENTRY-2:0],1'b1} on insert, i.e. low o_fill bits set.
- Full dictionary: an insert still shifts, the oldest entry is lost, and o_fill stays at DICT_ENTRY.
- Word visibility: the comparator sees the dictionary from before the held word is inserted. The next word compares against the updated dictionary in the following cycle; there is no bypass needed because update and present are on separate cycles.
- i_clear (synchronous, same edge behaviour as reset for dictionary state):
  - Entries=0, o_dict_valid=0, o_fill=0, o_word_valid=0.
  - Any held word is dropped without insertion.
  - o_ready=0 during the clear cycle, so no accept happens.
  - Clear wins over a simultaneous commit, which has no dictionary effect.
- i_type_matched and i_out_ready are ignored while o_word_valid=0.
- Upstream must hold i_word stable while i_valid=1 and o_ready=0; the block does not check this.

Decomposition:
- Package compress_pkg:
  - match_type_t enum {NONE, PART16, PART24, FULL} (2-bit).
  - DICT_WORD/DICT_ENTRY defaults.
  - Shared with the comparator array and the downstream encoder.
- One sub-module, dict_shift_reg: the DICT_ENTRY x DICT_WORD shift register with insert/clear and the valid mask.
- The top level holds the word register, handshake logic, fill counter and insert decision.

Test Plan:
- Reset then stream A1A1A1A1, B2B2B2B2, C3C3C3C3 with type NONE and i_out_ready=1 -> entry0=C3C3C3C3, entry1=B2B2B2B2, entry2=A1A1A1A1, o_fill=3, o_dict_valid=16'h0007; o_word trails i_word by 1 cycle.
- Fill with 17 distinct non-zero words of type NONE -> o_fill=16, o_dict_valid=16'hFFFF, first word gone, entry15=second word.
- Commit DEADBEEF with type FULL, then 00000000 with type NONE -> no dictionary change, o_fill unchanged.
- Hold i_out_ready=0 for 3 cycles with word 12345678 held and i_valid=1 -> o_ready=0, o_word stable, no insert; release -> insert on the release edge, next word accepted the same cycle.
- Assert i_clear with o_fill=5 and a word held -> next cycle o_fill=0, o_dict_valid=0, o_word_valid=0, o_ready=0 during the clear cycle.
- Assert i_rst_n=0 mid-stream with i_valid=1 -> all outputs zero after the edge; no accept while in reset.
